// File: rtl/rv_alu_pkg.sv
// Shared ALU control codes and the multiply/divide FSM state type.
// The decoder uses the same codes, so they are defined only here.
package rv_alu_pkg;

  localparam logic [3:0] ALU_MUL  = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_DIVU = 4'b1100;
  localparam logic [3:0] ALU_REM  = 4'b1101;
  localparam logic [3:0] ALU_REMU = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIN
  } muldiv_state_t;

  function automatic logic is_div_op(input logic [3:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU) ||
           (code == ALU_REM) || (code == ALU_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [3:0] code);
    return (code == ALU_DIV) || (code == ALU_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: a shift-add multiply step, or one restoring
// divide step that produces one quotient bit.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_mul,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] x_next,
  output logic [XLEN-1:0] y_next
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // Divide: y shifts the dividend out at the top and the quotient in at the
  // bottom. diff[XLEN] set means the trial subtraction borrowed.
  always_comb begin
    trial    = {acc, y[XLEN-1]};
    diff     = trial - {1'b0, x};
    acc_next = acc;
    x_next   = x;
    y_next   = y;
    if (is_mul) begin
      acc_next = acc + (y[0] ? x : '0);
      x_next   = x << 1;
      y_next   = y >> 1;
    end else if (!diff[XLEN]) begin
      acc_next = diff[XLEN-1:0];
      y_next   = {y[XLEN-2:0], 1'b1};
    end else begin
      acc_next = trial[XLEN-1:0];
      y_next   = {y[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execute unit: MUL, DIV, DIVU, REM and REMU.
// It stalls the pipeline through busy and returns a registered result with a done pulse.
module muldiv_unit
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state, state_next;
  logic [3:0]      op;
  logic [XLEN-1:0] acc, x, y;
  logic [XLEN-1:0] acc_step, x_step, y_step;
  logic [4:0]      cnt;
  logic            q_neg, r_neg;
  logic            div_zero, div_ovf, supported;
  logic [XLEN-1:0] fin_value;

  assign div_zero  = is_div_op(alu_ctrl) && (op_b == '0);
  assign div_ovf   = is_signed_div(alu_ctrl) && (op_a == MIN_INT) && (op_b == '1);
  assign supported = (alu_ctrl == ALU_MUL) || is_div_op(alu_ctrl);
  assign busy      = (state != ST_IDLE);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_mul   (op == ALU_MUL),
    .acc      (acc),
    .x        (x),
    .y        (y),
    .acc_next (acc_step),
    .x_next   (x_step),
    .y_next   (y_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = (supported && !div_zero && !div_ovf) ? ST_PREP : ST_FIN;
      ST_PREP: state_next = ST_RUN;
      ST_RUN:  if (cnt == 5'd0) state_next = ST_FIN;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // x holds multiplicand or divisor; y holds multiplier or dividend/quotient.
  // Shortcuts preload y (quotient) or acc (remainder) so FIN needs no special case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op    <= '0;
      acc   <= '0;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (!flush) begin
      case (state)
        ST_IDLE: if (start) begin
          op    <= alu_ctrl;
          x     <= op_b;
          q_neg <= 1'b0;
          r_neg <= 1'b0;
          if (div_zero) begin
            y   <= '1;
            acc <= op_a;
          end else if (div_ovf) begin
            y   <= MIN_INT;
            acc <= '0;
          end else begin
            y   <= op_a;
            acc <= '0;
          end
        end
        ST_PREP: begin
          if (is_signed_div(op)) begin
            x     <= x[XLEN-1] ? -x : x;
            y     <= y[XLEN-1] ? -y : y;
            q_neg <= x[XLEN-1] ^ y[XLEN-1];
            r_neg <= y[XLEN-1];
          end
          cnt <= 5'd31;
        end
        ST_RUN: begin
          acc <= acc_step;
          x   <= x_step;
          y   <= y_step;
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fin_value = '0;
    case (op)
      ALU_MUL:            fin_value = acc;
      ALU_DIV, ALU_DIVU:  fin_value = q_neg ? -y : y;
      ALU_REM, ALU_REMU:  fin_value = r_neg ? -acc : acc;
      default:            fin_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_FIN && !flush) begin
        done   <= 1'b1;
        result <= fin_value;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, busy/flush/reset
// behaviour, and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;
  import rv_alu_pkg::*;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // RV32M semantics computed directly with arithmetic operators
  function automatic logic [31:0] refResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      ALU_MUL:  r = a * b;
      ALU_DIV:  if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
      ALU_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM:  if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else r = $signed(a) % $signed(b);
      ALU_REMU: r = (b == 0) ? a : a % b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic int refLatency(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == ALU_MUL) return 35;
    if (op == ALU_DIV || op == ALU_DIVU || op == ALU_REM || op == ALU_REMU) begin
      if (b == 0) return 2;
      if ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 35;
    end
    return 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op in the current cycle; returns at the done cycle (or after a bound)
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat, output logic busyAtDone);
    alu_ctrl = op;
    op_a     = a;
    op_b     = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    lat   = 1;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    res        = result;
    busyAtDone = busy;
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input int expLat);
    logic [31:0] res;
    int          lat;
    logic        bsy;
    applyStimulus(op, a, b, res, lat, bsy);
    checkOutput({tag, ".result"}, res, expRes);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".busy_at_done"}, {31'b0, bsy}, 32'd0);
  endtask

  initial begin
    logic [31:0] held, captured, ra, rb, rnd;
    logic [3:0]  rop;
    int          doneCount, firstLat;

    $display("[TB] starting muldiv_unit bench");
    #12;
    checkOutput("reset.busy", {31'b0, busy}, 32'd0);
    checkOutput("reset.done", {31'b0, done}, 32'd0);
    checkOutput("reset.result", result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Directed cases; consecutive calls also start each op in the previous done cycle
    runOp("mul_7_neg3", ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
    runOp("div_neg7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    runOp("rem_neg7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    runOp("divu_big_2", ALU_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 35);
    runOp("divu_by0", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    runOp("remu_by0", ALU_REMU, 32'd5, 32'd0, 32'd5, 2);
    runOp("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    runOp("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
    runOp("div_by0", ALU_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, 2);
    runOp("rem_neg_by0", ALU_REM, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 2);
    runOp("unsupported", 4'b0011, 32'd9, 32'd3, 32'd0, 2);
    runOp("div_min_2", ALU_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 35);
    tick();
    checkOutput("done_pulse_width", {31'b0, done}, 32'd0);

    // Second start mid-run must be ignored: one done, first op's result
    doneCount = 0;
    firstLat  = 0;
    captured  = '0;
    for (int i = 0; i < 60; i++) begin
      if (i == 0) begin alu_ctrl = ALU_MUL; op_a = 32'd3; op_b = 32'd5; end
      if (i == 10) begin alu_ctrl = ALU_DIVU; op_a = 32'd100; op_b = 32'd7; end
      start = (i == 0 || i == 10);
      tick();
      if (done === 1'b1) begin
        doneCount++;
        if (doneCount == 1) begin firstLat = i + 1; captured = result; end
      end
    end
    start = 1'b0;
    checkOutput("busy_start.done_count", 32'(doneCount), 32'd1);
    checkOutput("busy_start.latency", 32'(firstLat), 32'd35);
    checkOutput("busy_start.result", captured, 32'd15);

    // Flush during the tenth RUN cycle: no done, result holds
    runOp("pre_flush", ALU_DIVU, 32'd1000, 32'd7, 32'd142, 35);
    held      = 32'd142;
    doneCount = 0;
    alu_ctrl  = ALU_DIVU;
    op_a      = 32'd77;
    op_b      = 32'd5;
    for (int i = 0; i < 50; i++) begin
      start = (i == 0);
      flush = (i == 11);
      tick();
      if (done === 1'b1) doneCount++;
    end
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flush.done_count", 32'(doneCount), 32'd0);
    checkOutput("flush.result_held", result, held);
    checkOutput("flush.busy", {31'b0, busy}, 32'd0);

    // Flush coincident with start in IDLE wins
    alu_ctrl = ALU_MUL;
    op_a     = 32'd2;
    op_b     = 32'd2;
    start    = 1'b1;
    flush    = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flush_start.busy", {31'b0, busy}, 32'd0);
    tick();
    tick();
    checkOutput("flush_start.result", result, held);

    runOp("after_flush", ALU_REMU, 32'd77, 32'd5, 32'd2, 35);

    // Asynchronous reset in the middle of RUN
    alu_ctrl = ALU_MUL;
    op_a     = 32'd12345;
    op_b     = 32'd678;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid.busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_mid.done", {31'b0, done}, 32'd0);
    checkOutput("reset_mid.result", result, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    runOp("after_reset", ALU_MUL, 32'd12345, 32'd678, 32'd8369910, 35);

    // Randomized ops against the reference model
    for (int n = 0; n < 24; n++) begin
      rnd = $urandom;
      case (rnd[2:0])
        3'd0:    rop = ALU_MUL;
        3'd1:    rop = ALU_DIV;
        3'd2:    rop = ALU_DIVU;
        3'd3:    rop = ALU_REM;
        3'd4:    rop = ALU_REMU;
        3'd5:    rop = ALU_DIV;
        3'd6:    rop = ALU_REM;
        default: rop = rnd[7:4];
      endcase
      ra = $urandom;
      rb = $urandom;
      if (rnd[10:8] == 3'd0) rb = '0;
      if (rnd[10:8] == 3'd1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if (rnd[10:8] == 3'd2) rb = rb >> rnd[15:11];
      runOp($sformatf("rand%0d_op%h", n, rop), rop, ra, rb, refResult(rop, ra, rb), refLatency(rop, ra, rb));
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
